// File: rtl/dct_avalon_master.sv
// -----------------------------------------------------------------------------
// dct_avalon_master
//
// Avalon-MM initiator that sequences one complete transform on an avalon_dct
// responder: on an accepted start it writes the fixed-point integer-bit count
// (address 2) and the log2 transform size (address 0). It then streams
// 2^log2n samples into address 1. Finally it reads coefficients 0..nout-1
// back and offers each one on a valid/ready output stream.
//
// Ports
//   Clock, ResetN          rising-edge clock, asynchronous active-low reset
//   start                  one-cycle request, honoured only while idle
//   cfg_m/log2n/nout       run configuration, latched on an accepted start
//   in_valid/ready/data    sample stream into the transform
//   av_*                   Avalon-MM initiator port towards the DCT
//   out_valid/ready        coefficient stream handshake
//   out_data/out_index     coefficient value and its index k
//   busy                   high whenever a run is in progress
//   err                    one-cycle pulse when a start had a bad config
// -----------------------------------------------------------------------------
module dct_avalon_master #(
  parameter int NBITS  = 16,
  parameter int ADDRW  = 8,
  parameter int MAXLOG = 6
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             start,
  input  logic [NBITS-1:0] cfg_m,
  input  logic [3:0]       cfg_log2n,
  input  logic [ADDRW-1:0] cfg_nout,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  output logic [ADDRW-1:0] av_addr,
  output logic             av_read,
  output logic             av_write,
  output logic [NBITS-1:0] av_writedata,
  input  logic [NBITS-1:0] av_readdata,
  input  logic             av_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data,
  output logic [ADDRW-1:0] out_index,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_M    = 3'd1,
    S_WR_SIZE = 3'd2,
    S_WR_SAMP = 3'd3,
    S_RD_REQ  = 3'd4,
    S_OUT     = 3'd5
  } state_t;

  // Sample counter carries one extra bit so a full 2^MAXLOG load does not wrap.
  localparam int CW = MAXLOG + 1;

  localparam logic [ADDRW-1:0] ADDR_SIZE = {ADDRW{1'b0}};
  localparam logic [ADDRW-1:0] ADDR_SAMP = {{(ADDRW-1){1'b0}}, 1'b1};
  localparam logic [ADDRW-1:0] ADDR_M    = {{(ADDRW-2){1'b0}}, 2'b10};
  localparam logic [ADDRW-1:0] ONE_A     = {{(ADDRW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ONE_C     = {{(CW-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [3:0]       log2n_r;
  logic [ADDRW-1:0] nout_r;
  logic [ADDRW-1:0] k_r;
  logic [CW-1:0]    cnt_r;
  logic [ADDRW-1:0] addr_r;
  logic             read_r;
  logic             cfg_wr_r;
  logic [NBITS-1:0] cfg_wdata_r;
  logic             out_valid_r;
  logic [NBITS-1:0] out_data_r;
  logic [ADDRW-1:0] out_index_r;
  logic             busy_r;
  logic             err_r;

  logic             cfg_ok_s;
  logic [ADDRW:0]   nmax_s;
  logic [CW-1:0]    nsamp_s;
  logic [CW-1:0]    cnt_next_s;
  logic [ADDRW-1:0] k_next_s;
  logic             samp_phase_s;

  assign nmax_s       = {{ADDRW{1'b0}}, 1'b1} << cfg_log2n;
  assign nsamp_s      = ONE_C << log2n_r;
  assign cnt_next_s   = cnt_r + ONE_C;
  assign k_next_s     = k_r + ONE_A;
  assign samp_phase_s = (state_r == S_WR_SAMP);

  // Validate the requested configuration before a run is allowed to begin.
  always_comb begin
    cfg_ok_s = 1'b1;
    if ((cfg_log2n == 4'd0) || (cfg_log2n > 4'(MAXLOG)) ||
        (cfg_nout == {ADDRW{1'b0}}) || ({1'b0, cfg_nout} > nmax_s)) begin
      cfg_ok_s = 1'b0;
    end else begin
      cfg_ok_s = 1'b1;
    end
  end

  // During sample streaming the write strobe and data follow the input stream
  // directly so a sample is written in the same cycle it is accepted.
  assign in_ready     = samp_phase_s;
  assign av_write     = samp_phase_s ? in_valid : cfg_wr_r;
  assign av_writedata = samp_phase_s ? in_data  : cfg_wdata_r;
  assign av_addr      = addr_r;
  assign av_read      = read_r;
  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign out_index    = out_index_r;
  assign busy         = busy_r;
  assign err          = err_r;

  // Run sequencer: config writes, sample load, then read/present per coefficient.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r     <= S_IDLE;
      log2n_r     <= 4'd0;
      nout_r      <= {ADDRW{1'b0}};
      k_r         <= {ADDRW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      addr_r      <= {ADDRW{1'b0}};
      read_r      <= 1'b0;
      cfg_wr_r    <= 1'b0;
      cfg_wdata_r <= {NBITS{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {NBITS{1'b0}};
      out_index_r <= {ADDRW{1'b0}};
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && cfg_ok_s) begin
            log2n_r     <= cfg_log2n;
            nout_r      <= cfg_nout;
            k_r         <= {ADDRW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            addr_r      <= ADDR_M;
            cfg_wr_r    <= 1'b1;
            cfg_wdata_r <= cfg_m;
            busy_r      <= 1'b1;
            state_r     <= S_WR_M;
          end else if (start) begin
            err_r <= 1'b1;
          end
        end
        S_WR_M: begin
          addr_r      <= ADDR_SIZE;
          cfg_wdata_r <= {{(NBITS-4){1'b0}}, log2n_r};
          state_r     <= S_WR_SIZE;
        end
        S_WR_SIZE: begin
          addr_r      <= ADDR_SAMP;
          cfg_wr_r    <= 1'b0;
          cfg_wdata_r <= {NBITS{1'b0}};
          state_r     <= S_WR_SAMP;
        end
        S_WR_SAMP: begin
          if (in_valid && (cnt_next_s == nsamp_s)) begin
            cnt_r   <= {CW{1'b0}};
            addr_r  <= k_r;
            read_r  <= 1'b1;
            state_r <= S_RD_REQ;
          end else if (in_valid) begin
            cnt_r <= cnt_next_s;
          end
        end
        S_RD_REQ: begin
          // Address and read stay put until the responder answers.
          if (av_done) begin
            out_data_r  <= av_readdata;
            out_index_r <= k_r;
            out_valid_r <= 1'b1;
            read_r      <= 1'b0;
            state_r     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready && (k_next_s == nout_r)) begin
            out_valid_r <= 1'b0;
            addr_r      <= {ADDRW{1'b0}};
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            k_r         <= k_next_s;
            addr_r      <= k_next_s;
            read_r      <= 1'b1;
            state_r     <= S_RD_REQ;
          end
        end
        default: begin
          read_r      <= 1'b0;
          cfg_wr_r    <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct_avalon_master.sv
// -----------------------------------------------------------------------------
// tb_dct_avalon_master
//
// Directed bench for dct_avalon_master. A small responder stores the samples
// written on the bus and answers reads with a coefficient derived from them.
// The expected bus writes and output beats are queued by each test from the
// intended stimulus. A single negedge process compares every write, every
// output beat and the hold/stability rules.
// -----------------------------------------------------------------------------
module tb_dct_avalon_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_m;
  logic [3:0]  cfg_log2n;
  logic [7:0]  cfg_nout;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  av_addr;
  logic        av_read;
  logic        av_write;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_index;
  logic        busy;
  logic        err;

  dct_avalon_master #(.NBITS(16), .ADDRW(8), .MAXLOG(6)) dut (
    .Clock(clk), .ResetN(rst_n), .start(start),
    .cfg_m(cfg_m), .cfg_log2n(cfg_log2n), .cfg_nout(cfg_nout),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .av_addr(av_addr), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .av_done(av_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  typedef struct { logic [7:0] k; logic [15:0] d; } beat_t;

  wr_t   exp_wr[$];
  beat_t exp_out[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_count, first_wr, last_wr, first_rd, rd_cycles, ov_cycles;
  int acc_count, beats, err_cnt, start_cyc, resp_lat;

  logic [15:0] stim [64];
  logic [15:0] got  [256];

  // Responder-side storage of the samples it was given.
  logic [15:0] r_s [64];
  int          r_n = 0;
  int          wait_cnt = 0;

  logic       p_read, p_done, p_ov, p_or;
  logic [7:0] p_addr, p_oi;
  logic [15:0] p_od;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Coefficient the responder returns for index k given n stored samples.
  function automatic logic [15:0] coef_of(input logic [15:0] s [64], input int n, input int k);
    int acc;
    acc = 0;
    for (int i = 0; i < n; i++) acc += $signed(s[i]) * (i + 1);
    acc += k * 7919;
    return acc[15:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: capture writes mid-cycle.
  always @(negedge clk) begin
    if (rst_n && av_write) begin
      if (av_addr == 8'd0) r_n = 0;
      else if (av_addr == 8'd1 && r_n < 64) begin
        r_s[r_n] = av_writedata;
        r_n++;
      end
    end
  end

  // Responder: answer a held read after resp_lat wait cycles.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      av_done = 1'b0; wait_cnt = 0; av_readdata = 16'h0BAD;
    end else if (av_read) begin
      if (wait_cnt >= resp_lat) begin
        av_done = 1'b1;
        av_readdata = coef_of(r_s, r_n, int'(av_addr));
      end else begin
        av_done = 1'b0; av_readdata = 16'h0BAD; wait_cnt++;
      end
    end else begin
      av_done = 1'b0; wait_cnt = 0; av_readdata = 16'h0BAD;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (av_read && av_write) chk("rd_wr_exclusive", 32'd1, 32'd0);
      if (av_write) begin
        wr_count++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (exp_wr.size() == 0) chk("unexpected_write", {24'd0, av_addr}, 32'hFFFF_FFFF);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", {24'd0, av_addr}, {24'd0, e.a});
          chk("wr_data", {16'd0, av_writedata}, {16'd0, e.d});
        end
      end
      if (in_ready) begin
        chk("wr_follows_valid", {31'd0, av_write}, {31'd0, in_valid});
        chk("samp_addr", {24'd0, av_addr}, 32'd1);
        if (in_valid) acc_count++;
      end
      if (av_read) begin
        rd_cycles++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (out_valid) ov_cycles++;
      if (p_read && !p_done) begin
        chk("read_held", {31'd0, av_read}, 32'd1);
        chk("addr_held", {24'd0, av_addr}, {24'd0, p_addr});
      end
      if (p_read && p_done) chk("valid_after_done", {31'd0, out_valid}, 32'd1);
      if (p_ov && !p_or) begin
        chk("out_valid_held", {31'd0, out_valid}, 32'd1);
        chk("out_data_held", {16'd0, out_data}, {16'd0, p_od});
        chk("out_index_held", {24'd0, out_index}, {24'd0, p_oi});
      end
      if (out_valid && out_ready) begin
        beats++;
        got[out_index] = out_data;
        if (exp_out.size() == 0) chk("unexpected_beat", {24'd0, out_index}, 32'hFFFF_FFFF);
        else begin
          beat_t b;
          b = exp_out.pop_front();
          chk("out_index", {24'd0, out_index}, {24'd0, b.k});
          chk("out_data", {16'd0, out_data}, {16'd0, b.d});
        end
      end
      if (err) err_cnt++;
      p_read = av_read; p_done = av_done; p_addr = av_addr;
      p_ov = out_valid; p_or = out_ready; p_od = out_data; p_oi = out_index;
    end else begin
      p_read = 1'b0; p_done = 1'b0; p_ov = 1'b0; p_or = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  {24'd0, av_addr}, 32'd0);
    chk({tag, "_read"},  {31'd0, av_read}, 32'd0);
    chk({tag, "_write"}, {31'd0, av_write}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, av_writedata}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_out_index"}, {24'd0, out_index}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"},  {31'd0, err}, 32'd0);
  endtask

  // One run: queue expectations from stim, pulse start, drive both streams.
  task automatic run_op(input int m, input int lg, input int nout, input bit gaps,
                        input int rlat, input int ohold, input bit extra,
                        input int abort_at, input bit busy_poke);
    int n, hold_c;
    bit done;
    n = 1 << lg;
    wr_count = 0; first_wr = -1; last_wr = -1; first_rd = -1; rd_cycles = 0;
    ov_cycles = 0; acc_count = 0; beats = 0; err_cnt = 0; resp_lat = rlat;
    exp_wr.delete(); exp_out.delete();
    exp_wr.push_back('{8'd2, 16'(m)});
    exp_wr.push_back('{8'd0, 16'(lg)});
    for (int i = 0; i < n; i++)
      if (abort_at == 0 || i < abort_at) exp_wr.push_back('{8'd1, stim[i]});
    if (abort_at == 0)
      for (int k = 0; k < nout; k++) exp_out.push_back('{8'(k), coef_of(stim, n, k)});
    @(posedge clk); #1;
    cfg_m = 16'(m); cfg_log2n = 4'(lg); cfg_nout = 8'(nout); start = 1'b1;
    start_cyc = cyc;
    done = 1'b0; hold_c = 0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy_poke && t == 30) begin
        start = 1'b1; cfg_nout = 8'd0; cfg_log2n = 4'd2;
      end
      if (acc_count < n) begin
        in_valid = gaps ? (t % 2 == 0) : 1'b1;
        in_data  = stim[acc_count];
      end else begin
        in_valid = extra;
        in_data  = 16'h7777;
      end
      if (out_valid) begin
        if (hold_c < ohold) begin out_ready = 1'b0; hold_c++; end
        else begin out_ready = 1'b1; hold_c = 0; end
      end else begin
        out_ready = 1'b0;
      end
      if (abort_at > 0 && acc_count == abort_at) begin
        in_valid = 1'b0; done = 1'b1;
      end else if (!busy) begin
        done = 1'b1;
      end
    end
    if (!done) chk("run_timeout", 32'd1, 32'd0);
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int n, input int nout,
                           input int rd_exp, input int ov_exp);
    chk({tag, "_writes"}, wr_count, n + 2);
    chk({tag, "_accepted"}, acc_count, n);
    chk({tag, "_first_wr"}, first_wr, start_cyc + 1);
    chk({tag, "_first_rd"}, first_rd, last_wr + 1);
    chk({tag, "_beats"}, beats, nout);
    chk({tag, "_rd_cycles"}, rd_cycles, rd_exp);
    chk({tag, "_ov_cycles"}, ov_cycles, ov_exp);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_out_left"}, exp_out.size(), 0);
    chk({tag, "_no_err"}, err_cnt, 0);
  endtask

  task automatic bad_start(input int lg, input int nout, input string tag);
    wr_count = 0; rd_cycles = 0; err_cnt = 0;
    @(posedge clk); #1;
    cfg_m = 16'd5; cfg_log2n = 4'(lg); cfg_nout = 8'(nout); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_err_hi"}, {31'd0, err}, 32'd1);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, "_err_lo"}, {31'd0, err}, 32'd0);
    repeat (4) @(negedge clk);
    chk({tag, "_busy1"}, {31'd0, busy}, 32'd0);
    chk({tag, "_no_bus"}, wr_count + rd_cycles, 0);
    chk({tag, "_one_pulse"}, err_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    real r;
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
    cfg_m = 16'd6; cfg_log2n = 4'd6; cfg_nout = 8'd20; out_ready = 1'b0;
    resp_lat = 0;
    av_done = 1'b0; av_readdata = 16'h0BAD;
    p_read = 1'b0; p_done = 1'b0; p_ov = 1'b0; p_or = 1'b0;
    p_addr = 8'd0; p_oi = 8'd0; p_od = 16'd0;

    // Reset with start and in_valid asserted.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal: M=6, 64 samples of 2cos(pi*i/64), Q6.9.
    for (int i = 0; i < 64; i++) begin
      r = 2.0 * $cos(3.14159265358979 * i / 64.0) * 512.0;
      stim[i] = 16'($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
    end
    chk("stim0", {16'd0, stim[0]}, 32'd1024);
    chk("stim16", {16'd0, stim[16]}, 32'd724);
    chk("stim32", {16'd0, stim[32]}, 32'd0);
    chk("stim63", {16'd0, stim[63]}, 32'h0000FC01);
    run_op(6, 6, 20, 1'b0, 0, 0, 1'b0, 0, 1'b1);
    check_run("nominal", 64, 20, 20, 20);
    chk("nominal_last_wr", last_wr - first_wr + 1, 66);

    // Gaps: in_valid toggles, extra samples offered after the 4th.
    for (int i = 0; i < 4; i++) stim[i] = 16'(i + 1);
    chk("model_coef0", {16'd0, coef_of(stim, 4, 0)}, 32'd30);
    chk("model_coef1", {16'd0, coef_of(stim, 4, 1)}, 32'd7949);
    run_op(3, 2, 4, 1'b1, 0, 0, 1'b1, 0, 1'b0);
    check_run("gaps", 4, 4, 4, 4);
    chk("gaps_got0", {16'd0, got[0]}, 32'd30);
    chk("gaps_got3", {16'd0, got[3]}, 32'd23787);
    @(negedge clk);
    chk("gaps_in_ready_low", {31'd0, in_ready}, 32'd0);

    // Backpressure: 5-cycle responder latency, 3-cycle consumer stall.
    for (int i = 0; i < 8; i++) stim[i] = 16'(i * 100 - 300);
    run_op(2, 3, 8, 1'b0, 5, 3, 1'b0, 0, 1'b0);
    check_run("bp", 8, 8, 48, 32);

    // Rejected configurations.
    bad_start(7, 1, "bad_log2n7");
    bad_start(0, 1, "bad_log2n0");
    bad_start(3, 0, "bad_nout0");
    bad_start(2, 5, "bad_nout5");

    // Mid-operation reset after 10 samples, then a clean restart.
    for (int i = 0; i < 64; i++) stim[i] = 16'(i * 3 + 1);
    run_op(6, 6, 20, 1'b0, 0, 0, 1'b0, 10, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    chk("midrst_writes", wr_count, 12);
    chk("midrst_accepted", acc_count, 10);
    chk("midrst_wr_left", exp_wr.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) stim[i] = 16'(16'h0100 - i * 17);
    run_op(4, 3, 8, 1'b0, 1, 1, 1'b0, 0, 1'b0);
    check_run("restart", 8, 8, 16, 16);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
